// File: rtl/mc_cfg_pkg.sv
// Shared definitions for the macrocell configuration loader: FSM encoding,
// frame geometry and the position of every select bit inside the payload.
package mc_cfg_pkg;

   // Payload length (parity bit excluded) and width of the bit counter
   localparam int FRAME_BITS = 20;
   localparam int CNT_W      = 5;

   // Loader FSM encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SHIFT = 3'd1;
   localparam logic [2:0] ST_CHECK = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   // Payload bit positions, index 0 is the first bit on the wire
   localparam int IDX_PT1      = 0;
   localparam int IDX_PT2      = 1;
   localparam int IDX_PT3      = 2;
   localparam int IDX_PT4      = 3;
   localparam int IDX_PT5      = 4;
   localparam int IDX_GCLR     = 5;
   localparam int IDX_PT4_FUNC = 6;
   localparam int IDX_PT5_FUNC = 7;
   localparam int IDX_XOR_A    = 8;
   localparam int IDX_XOR_B    = 9;
   localparam int IDX_XOR_INV  = 10;
   localparam int IDX_D        = 11;
   localparam int IDX_STORAGE  = 12;
   localparam int IDX_FB       = 13;
   localparam int IDX_O        = 14;
   localparam int IDX_OE0      = 15;
   localparam int IDX_OE1      = 16;
   localparam int IDX_OE2      = 17;
   localparam int IDX_GCLK0    = 18;
   localparam int IDX_GCLK1    = 19;

   // States in which a frame is still being assembled or judged
   function automatic logic isBusyState(input logic [2:0] st);
      return (st == ST_SHIFT) || (st == ST_CHECK);
   endfunction

endpackage

// File: rtl/mc_cfg_shift.sv
// Frame assembly: shadow register for the payload, bit counter and running
// parity over every accepted bit (payload plus parity bit).
module mc_cfg_shift
   import mc_cfg_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   input  logic                  i_shiftEn,
   input  logic                  i_data,
   output logic [FRAME_BITS-1:0] o_shadow,
   output logic                  o_parityPos,
   output logic                  o_parity
);

   logic [FRAME_BITS-1:0] r_shadow;
   logic [CNT_W-1:0]      r_count;
   logic                  r_parity;

   // Store each accepted bit at the counter position and fold it into parity;
   // the bit arriving at position FRAME_BITS is the parity bit and only
   // affects the running parity
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shadow <= '0;
         r_count  <= '0;
         r_parity <= 1'b0;
      end else if (i_clear) begin
         r_shadow <= '0;
         r_count  <= '0;
         r_parity <= 1'b0;
      end else if (i_shiftEn) begin
         for (int i = 0; i < FRAME_BITS; i++) begin
            if (r_count == CNT_W'(i)) begin
               r_shadow[i] <= i_data;
            end
         end
         r_count  <= r_count + CNT_W'(1);
         r_parity <= r_parity ^ i_data;
      end
   end

   assign o_shadow    = r_shadow;
   assign o_parityPos = (r_count == CNT_W'(FRAME_BITS));
   assign o_parity    = r_parity;

endmodule

// File: rtl/mc_config_loader.sv
// Serial configuration loader for one macrocell core: receives a 21-bit
// frame, checks even parity and commits the payload to the mux selects
// atomically, so a partial or corrupt frame never reaches the core.
module mc_config_loader
   import mc_cfg_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter bit PARITY_EN   = 1'b1
) (
   input  logic       clk_v,
   input  logic       rst_n_v,
   input  logic       cfg_start_v,
   input  logic       cfg_valid_v,
   input  logic       cfg_data_v,
   output logic       pt1_mux,
   output logic       pt2_mux,
   output logic       pt3_mux,
   output logic       pt4_mux,
   output logic       pt5_mux,
   output logic       gclr_mux,
   output logic       pt4_func_mux,
   output logic       pt5_func_mux,
   output logic       xor_a_mux,
   output logic       xor_b_mux,
   output logic       xor_inv_mux,
   output logic       d_mux,
   output logic       storage_mux,
   output logic       fb_mux,
   output logic       o_mux,
   output logic [0:2] oe_mux,
   output logic [0:1] gclk_mux,
   output logic       cfg_busy_v,
   output logic       cfg_done_v,
   output logic       cfg_err_v
);

   localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic [IDLE_W-1:0]     r_idle;
   logic [FRAME_BITS-1:0] r_cfg;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;

   logic                  w_clear;
   logic                  w_shiftEn;
   logic                  w_commit;
   logic                  w_parityOk;
   logic [FRAME_BITS-1:0] w_shadow;
   logic                  w_parityPos;
   logic                  w_parity;

   mc_cfg_shift u_shift (
      .i_clk       (clk_v),
      .i_rst_n     (rst_n_v),
      .i_clear     (w_clear),
      .i_shiftEn   (w_shiftEn),
      .i_data      (cfg_data_v),
      .o_shadow    (w_shadow),
      .o_parityPos (w_parityPos),
      .o_parity    (w_parity)
   );

   assign w_parityOk = !PARITY_EN || !w_parity;

   // Next-state decode; a start request restarts the frame from any state and
   // wins over a valid bit on the same edge
   always_comb begin
      w_next    = r_state;
      w_clear   = 1'b0;
      w_shiftEn = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cfg_start_v) begin
               w_next  = ST_SHIFT;
               w_clear = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cfg_start_v) begin
               w_next  = ST_SHIFT;
               w_clear = 1'b1;
            end else if (cfg_valid_v) begin
               w_shiftEn = 1'b1;
               if (w_parityPos) begin
                  w_next = ST_CHECK;
               end
            end else if (r_idle == IDLE_LAST) begin
               w_next = ST_ERR;
            end
         end
         ST_CHECK: begin
            if (cfg_start_v) begin
               w_next  = ST_SHIFT;
               w_clear = 1'b1;
            end else if (w_parityOk) begin
               w_next   = ST_DONE;
               w_commit = 1'b1;
            end else begin
               w_next = ST_ERR;
            end
         end
         ST_DONE: begin
            if (cfg_start_v) begin
               w_next  = ST_SHIFT;
               w_clear = 1'b1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_ERR: begin
            if (cfg_start_v) begin
               w_next  = ST_SHIFT;
               w_clear = 1'b1;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State register plus status flags registered from the next state so the
   // flags line up with the state they describe
   always_ff @(posedge clk_v or negedge rst_n_v) begin
      if (!rst_n_v) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= isBusyState(w_next);
         r_done  <= (w_next == ST_DONE);
         r_err   <= (w_next == ST_ERR);
      end
   end

   // Count consecutive edges without a valid bit while shifting
   always_ff @(posedge clk_v or negedge rst_n_v) begin
      if (!rst_n_v) begin
         r_idle <= '0;
      end else if (w_clear || w_shiftEn) begin
         r_idle <= '0;
      end else if ((r_state == ST_SHIFT) && (r_idle != IDLE_LAST)) begin
         r_idle <= r_idle + IDLE_W'(1);
      end
   end

   // Committed selects only change on the edge a checked frame is accepted
   always_ff @(posedge clk_v or negedge rst_n_v) begin
      if (!rst_n_v) begin
         r_cfg <= '0;
      end else if (w_commit) begin
         r_cfg <= w_shadow;
      end
   end

   assign pt1_mux      = r_cfg[IDX_PT1];
   assign pt2_mux      = r_cfg[IDX_PT2];
   assign pt3_mux      = r_cfg[IDX_PT3];
   assign pt4_mux      = r_cfg[IDX_PT4];
   assign pt5_mux      = r_cfg[IDX_PT5];
   assign gclr_mux     = r_cfg[IDX_GCLR];
   assign pt4_func_mux = r_cfg[IDX_PT4_FUNC];
   assign pt5_func_mux = r_cfg[IDX_PT5_FUNC];
   assign xor_a_mux    = r_cfg[IDX_XOR_A];
   assign xor_b_mux    = r_cfg[IDX_XOR_B];
   assign xor_inv_mux  = r_cfg[IDX_XOR_INV];
   assign d_mux        = r_cfg[IDX_D];
   assign storage_mux  = r_cfg[IDX_STORAGE];
   assign fb_mux       = r_cfg[IDX_FB];
   assign o_mux        = r_cfg[IDX_O];
   assign oe_mux       = {r_cfg[IDX_OE0], r_cfg[IDX_OE1], r_cfg[IDX_OE2]};
   assign gclk_mux     = {r_cfg[IDX_GCLK0], r_cfg[IDX_GCLK1]};
   assign cfg_busy_v   = r_busy;
   assign cfg_done_v   = r_done;
   assign cfg_err_v    = r_err;

endmodule

// File: tb/tb_mc_config_loader.sv
// Testbench for mc_config_loader: directed frames on a parity-checking
// instance and a parity-ignoring instance, with scoreboard monitors that
// compare each done/error event against the expected committed selects.
module tb_mc_config_loader;

   typedef struct packed {
      logic        isErr;
      logic [19:0] cfg;
   } expT;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic startV[2];
   logic validV[2];
   logic dataV[2];

   int checks = 0;
   int errors = 0;
   int doneCount0 = 0;
   int doneCount1 = 0;
   logic errPrev0 = 1'b0;
   logic errPrev1 = 1'b0;
   expT q0[$];
   expT q1[$];

   logic pt1_0, pt2_0, pt3_0, pt4_0, pt5_0, gclr0, pt4f0, pt5f0;
   logic xorA0, xorB0, xorInv0, d0, storage0, fb0, o0;
   logic [0:2] oe0;
   logic [0:1] gclk0;
   logic busy0, done0, err0;
   logic [19:0] out0;

   logic pt1_1, pt2_1, pt3_1, pt4_1, pt5_1, gclr1, pt4f1, pt5f1;
   logic xorA1, xorB1, xorInv1, d1, storage1, fb1, o1;
   logic [0:2] oe1;
   logic [0:1] gclk1;
   logic busy1, done1, err1;
   logic [19:0] out1;

   int dc;

   always #5 clk = ~clk;

   mc_config_loader #(.TIMEOUT_CYC(16), .PARITY_EN(1'b1)) dut0 (
      .clk_v(clk), .rst_n_v(rstN),
      .cfg_start_v(startV[0]), .cfg_valid_v(validV[0]), .cfg_data_v(dataV[0]),
      .pt1_mux(pt1_0), .pt2_mux(pt2_0), .pt3_mux(pt3_0), .pt4_mux(pt4_0), .pt5_mux(pt5_0),
      .gclr_mux(gclr0), .pt4_func_mux(pt4f0), .pt5_func_mux(pt5f0),
      .xor_a_mux(xorA0), .xor_b_mux(xorB0), .xor_inv_mux(xorInv0),
      .d_mux(d0), .storage_mux(storage0), .fb_mux(fb0), .o_mux(o0),
      .oe_mux(oe0), .gclk_mux(gclk0),
      .cfg_busy_v(busy0), .cfg_done_v(done0), .cfg_err_v(err0)
   );

   mc_config_loader #(.TIMEOUT_CYC(16), .PARITY_EN(1'b0)) dut1 (
      .clk_v(clk), .rst_n_v(rstN),
      .cfg_start_v(startV[1]), .cfg_valid_v(validV[1]), .cfg_data_v(dataV[1]),
      .pt1_mux(pt1_1), .pt2_mux(pt2_1), .pt3_mux(pt3_1), .pt4_mux(pt4_1), .pt5_mux(pt5_1),
      .gclr_mux(gclr1), .pt4_func_mux(pt4f1), .pt5_func_mux(pt5f1),
      .xor_a_mux(xorA1), .xor_b_mux(xorB1), .xor_inv_mux(xorInv1),
      .d_mux(d1), .storage_mux(storage1), .fb_mux(fb1), .o_mux(o1),
      .oe_mux(oe1), .gclk_mux(gclk1),
      .cfg_busy_v(busy1), .cfg_done_v(done1), .cfg_err_v(err1)
   );

   assign out0 = {gclk0[1], gclk0[0], oe0[2], oe0[1], oe0[0], o0, fb0, storage0, d0,
                  xorInv0, xorB0, xorA0, pt5f0, pt4f0, gclr0, pt5_0, pt4_0, pt3_0, pt2_0, pt1_0};
   assign out1 = {gclk1[1], gclk1[0], oe1[2], oe1[1], oe1[0], o1, fb1, storage1, d1,
                  xorInv1, xorB1, xorA1, pt5f1, pt4f1, gclr1, pt5_1, pt4_1, pt3_1, pt2_1, pt1_1};

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // All stimulus tasks start and end on a falling edge
   task automatic startFrame(input int tgt);
      startV[tgt] = 1'b1;
      validV[tgt] = 1'b1;
      dataV[tgt]  = 1'b1;
      @(negedge clk);
      startV[tgt] = 1'b0;
      validV[tgt] = 1'b0;
      dataV[tgt]  = 1'b0;
   endtask

   task automatic shiftBit(input int tgt, input logic b);
      validV[tgt] = 1'b1;
      dataV[tgt]  = b;
      @(negedge clk);
      validV[tgt] = 1'b0;
   endtask

   task automatic idle(input int tgt, input int n);
      validV[tgt] = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Full frame: start, 20 payload bits, parity bit, optional gap after gapAt
   task automatic applyStimulus(input int tgt, input logic [19:0] pay, input logic par,
                                input int gapAt, input int gapLen);
      startFrame(tgt);
      for (int i = 0; i < 20; i++) begin
         shiftBit(tgt, pay[i]);
         if (i == gapAt) idle(tgt, gapLen);
      end
      shiftBit(tgt, par);
   endtask

   // Scoreboard monitor for the parity-checking instance
   always @(negedge clk) begin
      if (rstN && (done0 || (err0 && !errPrev0))) begin
         if (done0) doneCount0++;
         if (q0.size() == 0) begin
            checkOutput("sb0_pending", q0.size(), 1);
         end else begin
            expT e;
            e = q0.pop_front();
            checkOutput("sb0_kind_err", err0, e.isErr);
            checkOutput("sb0_mux", out0, e.cfg);
         end
      end
      errPrev0 = err0;
   end

   // Scoreboard monitor for the parity-ignoring instance
   always @(negedge clk) begin
      if (rstN && (done1 || (err1 && !errPrev1))) begin
         if (done1) doneCount1++;
         if (q1.size() == 0) begin
            checkOutput("sb1_pending", q1.size(), 1);
         end else begin
            expT e;
            e = q1.pop_front();
            checkOutput("sb1_kind_err", err1, e.isErr);
            checkOutput("sb1_mux", out1, e.cfg);
         end
      end
      errPrev1 = err1;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         startV[i] = 1'b0;
         validV[i] = 1'b0;
         dataV[i]  = 1'b0;
      end

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_mux0", out0, 20'h0);
      checkOutput("rst_busy0", busy0, 1'b0);
      checkOutput("rst_done0", done0, 1'b0);
      checkOutput("rst_err0", err0, 1'b0);
      checkOutput("rst_mux1", out1, 20'h0);
      rstN = 1'b1;
      @(negedge clk);
      $display("[TB] reset released");

      // Alternating payload, correct parity, latency to done
      q0.push_back('{isErr: 1'b0, cfg: 20'h55555});
      applyStimulus(0, 20'h55555, 1'b0, -1, 0);
      @(posedge clk); #1;
      checkOutput("lat_done_e22", done0, 1'b1);
      checkOutput("lat_mux_e22", out0, 20'h55555);
      checkOutput("lat_busy_e22", busy0, 1'b0);
      checkOutput("lat_gclk", gclk0, 2'b10);
      @(posedge clk); #1;
      checkOutput("lat_done_e23", done0, 1'b0);
      @(negedge clk);

      // Same payload with a bad parity bit: error, selects unchanged
      q0.push_back('{isErr: 1'b1, cfg: 20'h55555});
      applyStimulus(0, 20'h55555, 1'b1, -1, 0);
      idle(0, 3);
      checkOutput("perr_sticky", err0, 1'b1);

      // Start clears the error; then stall for the timeout after bit 7
      startFrame(0);
      checkOutput("perr_cleared", err0, 1'b0);
      checkOutput("shift_busy", busy0, 1'b1);
      for (int i = 0; i < 7; i++) shiftBit(0, 1'b1);
      q0.push_back('{isErr: 1'b1, cfg: 20'h55555});
      idle(0, 15);
      checkOutput("tmo_15_err", err0, 1'b0);
      checkOutput("tmo_15_busy", busy0, 1'b1);
      idle(0, 1);
      checkOutput("tmo_16_err", err0, 1'b1);
      checkOutput("tmo_16_busy", busy0, 1'b0);

      // Restart after bit 10, then an all-ones frame
      dc = doneCount0;
      startFrame(0);
      for (int i = 0; i < 10; i++) shiftBit(0, 1'b1);
      q0.push_back('{isErr: 1'b0, cfg: 20'hFFFFF});
      applyStimulus(0, 20'hFFFFF, 1'b0, -1, 0);
      idle(0, 3);
      checkOutput("restart_done_pulses", doneCount0 - dc, 1);
      checkOutput("restart_mux", out0, 20'hFFFFF);

      // Frame with a short gap inside, odd payload so parity bit is 1
      q0.push_back('{isErr: 1'b0, cfg: 20'h3C5A1});
      applyStimulus(0, 20'h3C5A1, 1'b1, 3, 5);
      idle(0, 3);
      checkOutput("gap_mux", out0, 20'h3C5A1);
      checkOutput("gap_err", err0, 1'b0);

      // Asynchronous reset in the middle of a frame
      dc = doneCount0;
      startFrame(0);
      for (int i = 0; i < 15; i++) shiftBit(0, 1'b0);
      rstN = 1'b0;
      #1;
      checkOutput("arst_mux", out0, 20'h0);
      checkOutput("arst_busy", busy0, 1'b0);
      checkOutput("arst_done", done0, 1'b0);
      checkOutput("arst_err", err0, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
      idle(0, 30);
      checkOutput("arst_no_done", doneCount0 - dc, 0);
      checkOutput("arst_idle_busy", busy0, 1'b0);
      checkOutput("arst_mux_after", out0, 20'h0);

      // Parity ignored: wrong parity still commits
      q1.push_back('{isErr: 1'b0, cfg: 20'h0F0F3});
      applyStimulus(1, 20'h0F0F3, 1'b1, -1, 0);
      @(posedge clk); #1;
      checkOutput("nopar_done", done1, 1'b1);
      checkOutput("nopar_err", err1, 1'b0);
      checkOutput("nopar_mux", out1, 20'h0F0F3);
      @(negedge clk);
      idle(1, 3);
      checkOutput("nopar_done_count", doneCount1, 1);

      checkOutput("sb0_leftover", q0.size(), 0);
      checkOutput("sb1_leftover", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
